// File: rtl/filter_8b_8tap_window.sv
// 8-deep sample delay line feeding an 8-tap FIR stage as a 64-bit tap vector.
// Valid/ready on both sides, with output decimation by STRIDE and synchronous flush.
module filter_8b_8tap_window #(
  parameter int unsigned STRIDE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_window,
  output logic [3:0]  fill_level,
  output logic [15:0] window_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned WIN_W  = 64;
  localparam int unsigned FILL_W = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SC_W   = 8;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(8);
  localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(STRIDE - 1);

  logic [SC_W-1:0]   sc;
  logic [WIN_W-1:0]  win_n;
  logic [FILL_W-1:0] fill_n;
  logic [SC_W-1:0]   sc_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              m_valid_n;
  logic              accept;
  logic              handoff;
  logic              emit;

  // Only combinational path to an output: m_ready (plus reset/flush) to s_ready.
  assign s_ready = rst_n && !flush && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;
  assign handoff = m_valid && m_ready;

  always_comb begin
    win_n     = m_window;
    fill_n    = fill_level;
    sc_n      = sc;
    cnt_n     = window_count;
    m_valid_n = m_valid;
    emit      = 1'b0;

    if (handoff) begin
      m_valid_n = 1'b0;
      cnt_n     = window_count + CNT_W'(1);
    end

    if (accept) begin
      win_n = {m_window[WIN_W-DATA_W-1:0], s_data};
      if (fill_level == FILL_FULL) begin
        // Stride counts accepts since the last emitted window; emit on wrap.
        if (sc == SC_LAST) begin
          sc_n = '0;
          emit = 1'b1;
        end else begin
          sc_n = sc + SC_W'(1);
        end
      end else if (fill_level == FILL_FULL - FILL_W'(1)) begin
        fill_n = FILL_FULL;
        sc_n   = '0;
        emit   = 1'b1;
      end else begin
        fill_n = fill_level + FILL_W'(1);
      end
    end

    if (emit) begin
      m_valid_n = 1'b1;
    end

    // Flush drops any pending window without counting it as handed off.
    if (flush) begin
      win_n     = '0;
      fill_n    = '0;
      sc_n      = '0;
      m_valid_n = 1'b0;
      cnt_n     = window_count;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_window     <= '0;
      fill_level   <= '0;
      sc           <= '0;
      m_valid      <= 1'b0;
      window_count <= '0;
    end else begin
      m_window     <= win_n;
      fill_level   <= fill_n;
      sc           <= sc_n;
      m_valid      <= m_valid_n;
      window_count <= cnt_n;
    end
  end

endmodule
